// File: rtl/icache_responder.sv
// Direct-mapped instruction cache in front of the fetch unit: one word per line,
// single-word refills from the memory controller, jump flushes suppress pending responses.
module icache_responder #(
  parameter int INDEX_WIDTH = 6,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  pc_send_enable,
  input  logic [ADDR_WIDTH-1:0] pc_to_ic,
  input  logic                  jump_flag,
  output logic                  inst_get_ready,
  output logic [31:0]           inst_from_ic,
  output logic                  mem_req_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_data
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    MISS
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];
  logic [ADDR_WIDTH-1:2]   req_pc;
  logic                    cancel;

  logic [INDEX_WIDTH-1:0]  pc_idx;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;
  logic                    fill_en;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^pc_to_ic[1:0];

  always_comb begin
    pc_idx  = pc_to_ic[INDEX_WIDTH+1:2];
    pc_tag  = pc_to_ic[ADDR_WIDTH-1:INDEX_WIDTH+2];
    req_idx = req_pc[INDEX_WIDTH+1:2];
    req_tag = req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    hit     = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    fill_en = rst && rdy && (state == MISS) && mem_ready;
  end

  // Tag/data arrays need no reset: valid bits alone gate every lookup.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid          <= '0;
      state          <= IDLE;
      inst_get_ready <= 1'b0;
      inst_from_ic   <= '0;
      mem_req_enable <= 1'b0;
      mem_addr       <= '0;
      req_pc         <= '0;
      cancel         <= 1'b0;
    end else if (!rdy) begin
      inst_get_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          inst_get_ready <= 1'b0;
          cancel         <= 1'b0;
          if (pc_send_enable && !jump_flag) begin
            req_pc <= pc_to_ic[ADDR_WIDTH-1:2];
            if (hit) begin
              inst_from_ic   <= data_mem[pc_idx];
              inst_get_ready <= 1'b1;
              state          <= RESP;
            end else begin
              mem_addr       <= {pc_to_ic[ADDR_WIDTH-1:2], 2'b00};
              mem_req_enable <= 1'b1;
              state          <= MISS;
            end
          end
        end
        // Fetch enable is still high from the served request; ignore it here.
        RESP: begin
          inst_get_ready <= 1'b0;
          state          <= IDLE;
        end
        MISS: begin
          if (mem_ready) begin
            valid[req_idx] <= 1'b1;
            mem_req_enable <= 1'b0;
            cancel         <= 1'b0;
            if (!cancel && !jump_flag) begin
              inst_from_ic   <= mem_data;
              inst_get_ready <= 1'b1;
              state          <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (jump_flag) begin
            cancel <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: a cycle table for miss/hit/conflict traffic,
// then hand-written flush, stall and reset-mid-miss sequences.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        pc_send_enable;
  logic [31:0] pc_to_ic;
  logic        jump_flag;
  logic        inst_get_ready;
  logic [31:0] inst_from_ic;
  logic        mem_req_enable;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  int n_cmp = 0;
  int n_err = 0;

  icache_responder #(.INDEX_WIDTH(6), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .pc_send_enable(pc_send_enable),
    .pc_to_ic      (pc_to_ic),
    .jump_flag     (jump_flag),
    .inst_get_ready(inst_get_ready),
    .inst_from_ic  (inst_from_ic),
    .mem_req_enable(mem_req_enable),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_data      (mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] pc;
    logic        jump;
    logic        mr;
    logic [31:0] md;
    logic        e_igr;
    logic [31:0] e_inst;
    logic        e_mreq;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t v(logic r, logic en, logic [31:0] pc, logic j, logic mr,
                             logic [31:0] md, logic igr, logic [31:0] inst,
                             logic mreq, logic [31:0] maddr);
    vec_t t;
    t.rst = r; t.en = en; t.pc = pc; t.jump = j; t.mr = mr; t.md = md;
    t.e_igr = igr; t.e_inst = inst; t.e_mreq = mreq; t.e_maddr = maddr;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic igr, logic [31:0] inst,
                           logic mreq, logic [31:0] maddr);
    check({tag, ".inst_get_ready"}, {31'd0, inst_get_ready}, {31'd0, igr});
    check({tag, ".inst_from_ic"}, inst_from_ic, inst);
    check({tag, ".mem_req_enable"}, {31'd0, mem_req_enable}, {31'd0, mreq});
    check({tag, ".mem_addr"}, mem_addr, maddr);
  endtask

  task automatic drive(logic r, logic en, logic [31:0] pc, logic j, logic mr, logic [31:0] md);
    rst = r; pc_send_enable = en; pc_to_ic = pc; jump_flag = j; mem_ready = mr; mem_data = md;
  endtask

  initial begin
    rdy = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //                r  en  pc           j  mr  md            igr inst          mreq maddr
    tbl[0]  = v(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[1]  = v(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    tbl[2]  = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0);
    tbl[3]  = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0);
    tbl[4]  = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0);
    tbl[5]  = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b1, 32'h00100093, 1'b1, 32'h00100093, 1'b0, 32'h0);
    tbl[6]  = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h00100093, 1'b0, 32'h0);
    tbl[7]  = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 32'h00100093, 1'b0, 32'h0);
    tbl[8]  = v(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h00100093, 1'b0, 32'h0);
    tbl[9]  = v(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00100093, 1'b1, 32'h100);
    tbl[10] = v(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'h11111111, 1'b0, 32'h100);
    tbl[11] = v(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h11111111, 1'b0, 32'h100);
    tbl[12] = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h11111111, 1'b1, 32'h0);
    tbl[13] = v(1'b1, 1'b1, 32'h0,   1'b0, 1'b1, 32'h00100093, 1'b1, 32'h00100093, 1'b0, 32'h0);
    tbl[14] = v(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h00100093, 1'b0, 32'h0);
    tbl[15] = v(1'b1, 1'b1, 32'h3,   1'b0, 1'b0, 32'h0,        1'b1, 32'h00100093, 1'b0, 32'h0);
    tbl[16] = v(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h00100093, 1'b0, 32'h0);
    tbl[17] = v(1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0,        1'b0, 32'h00100093, 1'b0, 32'h0);
    tbl[18] = v(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h00100093, 1'b0, 32'h0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].pc, tbl[i].jump, tbl[i].mr, tbl[i].md);
      tick();
      check_all($sformatf("row%0d", i), tbl[i].e_igr, tbl[i].e_inst, tbl[i].e_mreq, tbl[i].e_maddr);
    end

    // Flush one cycle into a miss: fill completes silently, later hit returns it.
    drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0); tick();
    check_all("flush.req", 1'b0, 32'h00100093, 1'b1, 32'h40);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
    check_all("flush.jump", 1'b0, 32'h00100093, 1'b1, 32'h40);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    check_all("flush.wait", 1'b0, 32'h00100093, 1'b1, 32'h40);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF); tick();
    check_all("flush.fill", 1'b0, 32'h00100093, 1'b0, 32'h40);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    check_all("flush.quiet", 1'b0, 32'h00100093, 1'b0, 32'h40);
    drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0); tick();
    check_all("flush.hit", 1'b1, 32'hDEADBEEF, 1'b0, 32'h40);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();

    // Jump coinciding with mem_ready: line written, response suppressed.
    drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0); tick();
    check_all("same.req", 1'b0, 32'hDEADBEEF, 1'b1, 32'h80);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D); tick();
    check_all("same.fill", 1'b0, 32'hDEADBEEF, 1'b0, 32'h80);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    check_all("same.quiet", 1'b0, 32'hDEADBEEF, 1'b0, 32'h80);
    drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0); tick();
    check_all("same.hit", 1'b1, 32'hCAFEF00D, 1'b0, 32'h80);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();

    // rdy stall during a miss, then during the response cycle.
    drive(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0); tick();
    check_all("stall.req", 1'b0, 32'hCAFEF00D, 1'b1, 32'hC0);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("stall.hold%0d", i), 1'b0, 32'hCAFEF00D, 1'b1, 32'hC0);
    end
    rdy = 1'b1; tick();
    check_all("stall.resume", 1'b0, 32'hCAFEF00D, 1'b1, 32'hC0);
    drive(1'b1, 1'b1, 32'hC0, 1'b0, 1'b1, 32'h12345678); tick();
    check_all("stall.fill", 1'b1, 32'h12345678, 1'b0, 32'hC0);
    drive(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0); rdy = 1'b0; tick();
    check_all("stall.resp_frozen", 1'b0, 32'h12345678, 1'b0, 32'hC0);
    rdy = 1'b1; tick();
    check_all("stall.resp_exit", 1'b0, 32'h12345678, 1'b0, 32'hC0);
    tick();
    check_all("stall.hit", 1'b1, 32'h12345678, 1'b0, 32'hC0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();

    // Reset during a miss abandons it; the same pc misses again.
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0); tick();
    check_all("rstmiss.req", 1'b0, 32'h12345678, 1'b1, 32'h200);
    drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h55555555); tick();
    check_all("rstmiss.reset", 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    check_all("rstmiss.idle", 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0); tick();
    check_all("rstmiss.again", 1'b0, 32'h0, 1'b1, 32'h200);
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h0BADF00D); tick();
    check_all("rstmiss.fill", 1'b1, 32'h0BADF00D, 1'b0, 32'h200);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    check_all("rstmiss.done", 1'b0, 32'h0BADF00D, 1'b0, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache that serves the fetch unit's request/ready protocol (pc_send_enable / pc_to_ic in, inst_get_ready / inst_from_ic out).
- Hits respond one cycle after the request is sampled.
- Misses issue a single-word read to the memory controller, fill the line, then respond.
- A jump flush cancels any pending response; a memory fill already in flight still completes.

Parameters:
- INDEX_WIDTH, 6, log2 of the line count (64 lines, one 32-bit word per line).
- ADDR_WIDTH, 32, address width; tag = pc[ADDR_WIDTH-1 : INDEX_WIDTH+2].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (rst==0 at posedge resets)
- rdy  in  1  global ready; 0 freezes the block
- pc_send_enable  in  1  fetch request valid; held high by the fetch unit until served
- pc_to_ic  in  32  fetch address, word-aligned
- jump_flag  in  1  pipeline flush; cancels any pending response
- inst_get_ready  out  1  one-cycle pulse: inst_from_ic is valid for the current request
- inst_from_ic  out  32  instruction word
- mem_req_enable  out  1  read request to the memory controller, held until mem_ready
- mem_addr  out  32  word-aligned refill address
- mem_ready  in  1  one-cycle pulse: mem_data is valid
- mem_data  in  32  refill word

Behaviour:
- Reset (rst==0 at posedge): all valid bits cleared; state=IDLE; inst_get_ready=0; inst_from_ic=0; mem_req_enable=0; mem_addr=0. Reset mid-miss abandons the miss; no fill occurs.
- rdy==0 (rst==1): all state, arrays and outputs hold, except inst_get_ready forced to 0. A mem_ready arriving while rdy==0 is not captured.
- Storage: valid[2^INDEX_WIDTH], tag array, data array. Index = pc[INDEX_WIDTH+1:2]. pc[1:0] is ignored.
- FSM states:
  - IDLE: if pc_send_enable && !jump_flag, latch pc into req_pc and look it up.
    - Hit: inst_from_ic<=data; inst_get_ready<=1; go RESP.
    - Miss: mem_addr<={pc[31:2],2'b00}; mem_req_enable<=1; go MISS.
  - RESP: inst_get_ready<=0; go IDLE. Requests are ignored in this cycle, because the fetch unit's enable is still high from the served request. Hit throughput is therefore one instruction per 2 cycles, matching the fetch unit.
  - MISS: wait for mem_ready.
    - On mem_ready: write valid/tag/data at req_pc's index; mem_req_enable<=0.
    - If no flush is recorded: inst_from_ic<=mem_data; inst_get_ready<=1; go RESP.
    - Otherwise: go IDLE silently.
- Flush:
  - jump_flag in IDLE: the request in that cycle is not accepted.
  - jump_flag in RESP: inst_get_ready<=0 as normal (the fetch unit discards it).
  - jump_flag in MISS: set cancel flag. The fill still completes, but no response is issued. The cancel flag clears on return to IDLE.
  - jump_flag and mem_ready in the same cycle: the fill is written and the response is suppressed.
- Latency: hit = 1 cycle after the request is sampled. Miss = memory latency + 1 cycle.
- inst_get_ready is never high for two consecutive cycles.
- mem_req_enable never rises while already high.
- Writes of the same index overwrite the line; no associativity.
- No write/self-modifying-code support; no invalidate port.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request pc=0x0000_0000; memory returns 0x0010_0093 after 3 cycles.
  - Required: mem_req_enable=1 with mem_addr=0 the cycle after the request; inst_get_ready=1 and inst_from_ic=0x0010_0093 one cycle after mem_ready.
- Hit:
  - Stimulus: re-request pc=0x0.
  - Required: inst_get_ready=1 exactly 1 cycle later with 0x0010_0093; mem_req_enable stays 0.
- Conflict:
  - Stimulus: fill pc=0x000 then pc=0x100 (same index with INDEX_WIDTH=6), then request 0x000 again.
  - Required: the third request misses and mem_addr=0x000.
- Flush during miss:
  - Stimulus: request pc=0x40; jump_flag pulses 1 cycle into MISS; memory returns 0xDEADBEEF.
  - Required: no inst_get_ready pulse. A subsequent request to 0x40 hits with 0xDEADBEEF.
- rdy stall:
  - Stimulus: drop rdy for 4 cycles while in MISS; mem_ready held off until rdy returns.
  - Required: mem_req_enable and mem_addr stable throughout; the response is delivered normally afterwards.
- Reset mid-miss:
  - Stimulus: assert rst=0 while in MISS, release, then request the same pc.
  - Required: all outputs are 0 after reset, and the request misses again.
